// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard controller for the five-stage RISC-V core.
// Drives PC/F-D/D-X/X-M/M-W stall, hold and flush controls plus the execute-stage
// forwarding selects; counts post-redirect fetch bubbles for the synchronous I-mem.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   d_rs1/d_rs2, x_rs1/x_rs2     source registers of the instructions in D and X
//   x_rd, x_reg_write_enabled,
//   x_writeback_select           destination/write info of the instruction in X
//   x_branch_taken, x_jump       control-flow redirect resolved in X
//   m_rd/w_rd, m_/w_reg_write_enabled   destination info in M and W (forwarding)
//   m_mem_busy                   data memory wait state; whole back end freezes
//   pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, dx_hold, xm_hold, mw_bubble
//                                pipeline register controls (combinational)
//   forward_a_select/_b_select   0 = register file, 1 = M result, 2 = W result
//   stall_count, flush_count, freeze_count   32-bit wrap-around perf counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the performance counters;
// when it is undefined the counter ports are tied to zero and no flops exist.
//
// Latency: all controls are combinational from inputs and registered state.
// Backpressure: m_mem_busy freezes PC, F/D, D/X and X/M and bubbles M/W.

module hazard_control #(
  parameter int         REDIRECT_BUBBLES = 1,     // 0..3 extra fetch bubbles
  parameter logic [1:0] WB_SEL_MEM       = 2'd2   // writeback_select of a load
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic [4:0]  x_rs1,
  input  logic [4:0]  x_rs2,
  input  logic [4:0]  x_rd,
  input  logic        x_reg_write_enabled,
  input  logic [1:0]  x_writeback_select,
  input  logic        x_branch_taken,
  input  logic        x_jump,
  input  logic [4:0]  m_rd,
  input  logic [4:0]  w_rd,
  input  logic        m_reg_write_enabled,
  input  logic        w_reg_write_enabled,
  input  logic        m_mem_busy,
  output logic        pc_stall,
  output logic        fd_stall,
  output logic        fd_flush,
  output logic        dx_stall,
  output logic        dx_flush,
  output logic        dx_hold,
  output logic        xm_hold,
  output logic        mw_bubble,
  output logic [1:0]  forward_a_select,
  output logic [1:0]  forward_b_select,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
);

  localparam logic [1:0] BUBBLE_INIT = 2'(REDIRECT_BUBBLES);

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic redirect;

  // A load in X whose result is needed by D cannot be forwarded in time; the
  // bubble lets the load reach M so the consumer picks it up from W forwarding.
  assign load_use = x_reg_write_enabled
                 && (x_writeback_select == WB_SEL_MEM)
                 && (x_rd != 5'd0)
                 && ((x_rd == d_rs1) || (x_rd == d_rs2));

  assign redirect = x_branch_taken || x_jump;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      bubble_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and pipeline controls, highest priority first
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bubble_cnt_d = bubble_cnt_q;
    pc_stall     = 1'b0;
    fd_stall     = 1'b0;
    fd_flush     = 1'b0;
    dx_stall     = 1'b0;
    dx_flush     = 1'b0;
    dx_hold      = 1'b0;
    xm_hold      = 1'b0;
    mw_bubble    = 1'b0;

    if (reset) begin
      // Pipeline registers load NOPs while the core is held in reset.
      fd_flush     = 1'b1;
      dx_flush     = 1'b1;
      state_d      = RUN;
      bubble_cnt_d = 2'd0;
    end else if (m_mem_busy) begin
      // Everything upstream of M/W freezes; the branch in X stays put and is
      // resolved again once memory is ready. State and counter hold.
      pc_stall  = 1'b1;
      fd_stall  = 1'b1;
      dx_hold   = 1'b1;
      xm_hold   = 1'b1;
      mw_bubble = 1'b1;
    end else if (redirect) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      if (BUBBLE_INIT != 2'd0) begin
        state_d      = REDIRECT;
        bubble_cnt_d = BUBBLE_INIT;
      end else begin
        state_d      = RUN;
        bubble_cnt_d = 2'd0;
      end
    end else if (state_q == REDIRECT) begin
      // The synchronous I-mem still returns stale words: keep squashing F/D.
      fd_flush = 1'b1;
      if (bubble_cnt_q <= 2'd1) begin
        state_d      = RUN;
        bubble_cnt_d = 2'd0;
      end else begin
        bubble_cnt_d = bubble_cnt_q - 2'd1;
      end
    end else if (load_use) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      dx_stall = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects; M is the younger result so it wins over W
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mrd, input logic mwe,
                                         input logic [4:0] wrd, input logic wwe);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mwe && (mrd != 5'd0) && (mrd == rs)) begin
      sel = FWD_M;
    end else if (wwe && (wrd != 5'd0) && (wrd == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a_select = FWD_RF;
    forward_b_select = FWD_RF;
    if (!reset) begin
      forward_a_select = fwd_sel(x_rs1, m_rd, m_reg_write_enabled,
                                 w_rd, w_reg_write_enabled);
      forward_b_select = fwd_sel(x_rs2, m_rd, m_reg_write_enabled,
                                 w_rd, w_reg_write_enabled);
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  // dx_stall is only raised by a load-use stall and dx_flush only by a redirect
  // or reset, so the events come straight from the decoded controls.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (dx_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (dx_flush && !reset) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if (m_mem_busy && !reset) begin
      freeze_cnt_d = freeze_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      freeze_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign freeze_count = freeze_cnt_q;
`else
  assign stall_count  = 32'd0;
  assign flush_count  = 32'd0;
  assign freeze_count = 32'd0;
`endif

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard controller for the five-stage RISC-V core: it drives the stall, hold and flush inputs of the pipeline registers and the PC, and the execute-stage forwarding selects. It detects load-use hazards between D and X, taken branches/jumps resolved in X, and data-memory wait states. A small state machine counts the post-redirect bubbles needed by the synchronous instruction memory.

## Interface
- REDIRECT_BUBBLES, 1, extra fetch-side bubble cycles after a redirect; legal range 0..3.
- WB_SEL_MEM, 2'd2, writeback_select encoding that marks a load.

Clock and reset: one clock; reset is synchronous and active-high.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- d_rs1, d_rs2  in  5 each  source registers of the instruction in D
- x_rs1, x_rs2  in  5 each  source registers of the instruction in X
- x_rd  in  5  destination register in X
- x_reg_write_enabled  in  1  X writes the register file
- x_writeback_select  in  2  X writeback source
- x_branch_taken  in  1  branch in X resolved taken
- x_jump  in  1  jump in X
- m_rd, w_rd  in  5 each  destination registers in M and W
- m_reg_write_enabled, w_reg_write_enabled  in  1 each  register-file write enables in M and W
- m_mem_busy  in  1  data memory not ready; M must hold
- pc_stall  out  1  hold the PC
- fd_stall  out  1  hold the F/D register
- fd_flush  out  1  load a NOP into F/D
- dx_stall  out  1  insert a bubble into D/X (the D/X stall/flush input)
- dx_flush  out  1  squash D/X on redirect
- dx_hold, xm_hold  out  1 each  freeze D/X and X/M contents
- mw_bubble  out  1  load a NOP into M/W
- forward_a_select, forward_b_select  out  2 each  0 = register file, 1 = M result, 2 = W result
- stall_count, flush_count, freeze_count  out  32 each  performance counters

## Operation
- All control outputs are combinational from the current inputs and the registered state. Pipeline registers sample them at the next posedge.
- States: RUN, REDIRECT. The registered bubble counter is 2 bits wide.
- Conditions:
  - load_use = x_reg_write_enabled && x_writeback_select==WB_SEL_MEM && x_rd!=0 && (x_rd==d_rs1 || x_rd==d_rs2).
  - redirect = x_branch_taken || x_jump.
- Priority, highest first:
  1. reset: fd_flush=dx_flush=1; all other control outputs 0; forward selects 0.
  2. freeze (m_mem_busy=1): pc_stall=fd_stall=dx_hold=xm_hold=mw_bubble=1; all flushes 0. State and counter hold. A branch in X is re-evaluated after the freeze.
  3. redirect: fd_flush=dx_flush=1 and no stall. If REDIRECT_BUBBLES>0, next state is REDIRECT with counter=REDIRECT_BUBBLES.
  4. REDIRECT state: fd_flush=1 and the counter decrements. When the counter is 1, next state is RUN. A new redirect reloads the counter.
  5. load_use in RUN: pc_stall=fd_stall=dx_stall=1 for exactly one cycle; the hazard clears once the load reaches M.
- Forwarding for each operand, where rs is x_rs1 (A) or x_rs2 (B):
  - select 1 if m_reg_write_enabled && m_rd!=0 && m_rd==rs;
  - otherwise select 2 if the same test holds for W;
  - otherwise select 0.
  - M wins over W when both match. Register x0 is never forwarded.

## Timing
- Detection to effect is 0 cycles combinational. The bubble lands in D/X at the following posedge.
- A load-use costs 1 cycle. A redirect costs 2+REDIRECT_BUBBLES cycles. A freeze costs as many cycles as m_mem_busy is high.
- Reset: after a cycle with reset=1, state=RUN, counter=0 and all perf counters=0.
- Reset mid-REDIRECT aborts the redirect; the next cycle is RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined: the three counters are active. Each is 32-bit wrap-around.
  - stall_count increments on each load_use stall cycle.
  - flush_count increments on each redirect event.
  - freeze_count increments on each m_mem_busy cycle.
- HAZARD_PERF_CNT_EN undefined: the counter ports remain and are tied to 0, and no counter flops are generated.

## Test plan
- Load-use: X = load with x_rd=5 and writeback_select=2, D with d_rs2=5 -> pc_stall=fd_stall=dx_stall=1 for one cycle, then 0; stall_count=1 (counters enabled).
- Load to x0: x_rd=0, d_rs1=0 -> no stall.
- Redirect with REDIRECT_BUBBLES=1: x_branch_taken pulse -> fd_flush=dx_flush=1 in cycle 0, fd_flush=1 only in cycle 1, then RUN; flush_count=1.
- Freeze over redirect: m_mem_busy=1 for 3 cycles while x_jump=1 -> freeze outputs for 3 cycles with no flushes, then the redirect sequence; freeze_count=3.
- Forwarding: x_rs1=7 with m_rd=7 and w_rd=7 both writing -> forward_a_select=1. With m_reg_write_enabled=0 -> forward_a_select=2.
- Reset asserted in REDIRECT state -> next cycle RUN with all counters 0, and fd_flush=dx_flush=1 during reset.
